// File: rtl/io_capture_pkg.sv
// Shared types and sizing helpers for the IO capture/deskew block.
package io_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    WINDOW,
    VERIFY,
    LOCKED,
    FAIL
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Width of a delay tap index; never narrower than one bit.
  function automatic int unsigned dw_of(input int unsigned max_skew);
    return (max_skew == 0) ? 1 : clog2(max_skew + 1);
  endfunction

endpackage

// File: rtl/io_skew_line.sv
// Free-running per-lane delay line with a selectable output tap.
module io_skew_line #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [W-1:0]  d_i,
  input  logic [TW-1:0] tap_i,
  output logic [W-1:0]  q_o
);

  logic [W-1:0] line_q [DEPTH];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign q_o = (32'(tap_i) < DEPTH) ? line_q[tap_i] : '0;

endmodule

// File: rtl/io_capture_deskew.sv
// IOB capture registers, per-lane skew lines and marker-based training FSM
// that measures inter-lane skew and programs the lane delays.
module io_capture_deskew
  import io_capture_pkg::*;
#(
  parameter int unsigned        LANES     = 4,
  parameter int unsigned        LANE_W    = 8,
  parameter int unsigned        MAX_SKEW  = 3,
  parameter int unsigned        PIPE      = 1,
  parameter logic [LANE_W-1:0]  TRAIN_PAT = LANE_W'(8'hA5),
  parameter int unsigned        LOCK_CNT  = 4,
  parameter int unsigned        TIMEOUT   = 1024,
  localparam int unsigned       DW        = dw_of(MAX_SKEW)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Set,
  input  logic                      Enable,
  input  logic                      Train,
  input  logic [LANES*LANE_W-1:0]   In,
  output logic [LANES*LANE_W-1:0]   Out,
  output logic                      OutValid,
  output logic                      Locked,
  output logic                      TrainFail,
  output logic [LANES*DW-1:0]       LaneDelay
);

  localparam int unsigned TCW = clog2(TIMEOUT + 1);
  localparam int unsigned VCW = clog2(LOCK_CNT + 1);

  (* iob = "true" *) logic [LANE_W-1:0] cap_q [LANES];
  logic                  v0_q;
  logic [LANE_W:0]       tap_w [LANES];
  logic [LANES*LANE_W-1:0] tap_word;
  logic                  tap_valid;
  logic [LANES-1:0]      cap_match, tap_match;

  state_e          state_q, state_d;
  logic [DW-1:0]   wcnt_q, wcnt_d;
  logic [VCW-1:0]  vcnt_q, vcnt_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
  logic [LANES-1:0] rec_q, rec_d;
  logic [DW-1:0]   off_q [LANES];
  logic [DW-1:0]   off_d [LANES];
  logic [DW-1:0]   delay_q [LANES];
  logic [DW-1:0]   delay_d [LANES];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned l = 0; l < LANES; l++) cap_q[l] <= '0;
      v0_q <= 1'b0;
    end else if (Set) begin
      for (int unsigned l = 0; l < LANES; l++) cap_q[l] <= '1;
      v0_q <= 1'b0;
    end else if (Enable) begin
      for (int unsigned l = 0; l < LANES; l++) cap_q[l] <= In[l*LANE_W +: LANE_W];
      v0_q <= 1'b1;
    end else begin
      v0_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    io_skew_line #(.W(LANE_W + 1), .DEPTH(MAX_SKEW + 1), .TW(DW)) u_line (
      .Clock (Clock),
      .Reset (Reset),
      .d_i   ({cap_q[g], v0_q}),
      .tap_i (delay_q[g]),
      .q_o   (tap_w[g])
    );
  end

  always_comb begin
    tap_word  = '0;
    tap_valid = 1'b1;
    cap_match = '0;
    tap_match = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      tap_word[l*LANE_W +: LANE_W] = tap_w[l][LANE_W:1];
      tap_valid    = tap_valid & tap_w[l][0];
      cap_match[l] = v0_q && (cap_q[l] == TRAIN_PAT);
      tap_match[l] = tap_w[l][0] && (tap_w[l][LANE_W:1] == TRAIN_PAT);
    end
  end

  if (PIPE == 0) begin : g_nopipe
    assign Out      = tap_word;
    assign OutValid = tap_valid;
  end else begin : g_pipe
    logic [LANES*LANE_W:0] pipe_q [PIPE];
    always_ff @(posedge Clock) begin
      if (Reset) begin
        for (int unsigned i = 0; i < PIPE; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= {tap_valid, tap_word};
        for (int unsigned i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign Out      = pipe_q[PIPE-1][LANES*LANE_W-1:0];
    assign OutValid = pipe_q[PIPE-1][LANES*LANE_W];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      vcnt_q  <= '0;
      tcnt_q  <= '0;
      rec_q   <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        off_q[l]   <= '0;
        delay_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      vcnt_q  <= vcnt_d;
      tcnt_q  <= tcnt_d;
      rec_q   <= rec_d;
      off_q   <= off_d;
      delay_q <= delay_d;
    end
  end

  always_comb begin
    logic [DW-1:0] max_off;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    vcnt_d  = vcnt_q;
    tcnt_d  = tcnt_q;
    rec_d   = rec_q;
    off_d   = off_q;
    delay_d = delay_q;
    max_off = '0;
    if (Train) begin
      state_d = SEARCH;
      wcnt_d  = '0;
      vcnt_d  = '0;
      tcnt_d  = '0;
      rec_d   = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        off_d[l]   = '0;
        delay_d[l] = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        SEARCH: begin
          if (|cap_match) begin
            state_d = WINDOW;
            wcnt_d  = '0;
            tcnt_d  = '0;
            rec_d   = cap_match;
            for (int unsigned l = 0; l < LANES; l++) off_d[l] = '0;
          end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
            state_d = FAIL;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        WINDOW: begin
          // Offset recorded is the post-increment count: cycles since the first marker.
          wcnt_d = wcnt_q + 1'b1;
          for (int unsigned l = 0; l < LANES; l++) begin
            if (cap_match[l] && !rec_q[l]) begin
              rec_d[l] = 1'b1;
              off_d[l] = wcnt_d;
            end
          end
          if (wcnt_d == DW'(MAX_SKEW)) begin
            if (&rec_d) begin
              for (int unsigned l = 0; l < LANES; l++)
                if (off_d[l] > max_off) max_off = off_d[l];
              for (int unsigned l = 0; l < LANES; l++)
                delay_d[l] = max_off - off_d[l];
              state_d = VERIFY;
              vcnt_d  = '0;
              tcnt_d  = '0;
            end else begin
              state_d = FAIL;
            end
          end
        end
        VERIFY: begin
          if (&tap_match) begin
            tcnt_d = '0;
            vcnt_d = vcnt_q + 1'b1;
            if (vcnt_d == VCW'(LOCK_CNT)) state_d = LOCKED;
          end else if (|tap_match) begin
            state_d = SEARCH;
            vcnt_d  = '0;
            tcnt_d  = '0;
            rec_d   = '0;
            for (int unsigned l = 0; l < LANES; l++) delay_d[l] = '0;
          end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
            state_d = FAIL;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        LOCKED: ;
        FAIL: ;
        default: state_d = IDLE;
      endcase
      if (state_d == FAIL)
        for (int unsigned l = 0; l < LANES; l++) delay_d[l] = '0;
    end
  end

  always_comb begin
    Locked    = (state_q == LOCKED);
    TrainFail = (state_q == FAIL);
    LaneDelay = '0;
    for (int unsigned l = 0; l < LANES; l++) LaneDelay[l*DW +: DW] = delay_q[l];
  end

endmodule

// File: tb/tb_io_capture_deskew.sv
// Scoreboard bench for io_capture_deskew: capture/latency, training with skew, timeouts, reset.
module tb_io_capture_deskew;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DW     = 2;

  logic                    Clock = 1'b0;
  logic                    Reset, Set, Enable, Train;
  logic [LANES*LANE_W-1:0] In;
  logic [LANES*LANE_W-1:0] Out;
  logic                    OutValid, Locked, TrainFail;
  logic [LANES*DW-1:0]     LaneDelay;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  bit sb_en = 1'b0;
  int skew[LANES];
  int seed = 0;

  always #5 Clock = ~Clock;

  io_capture_deskew #(
    .LANES(LANES), .LANE_W(LANE_W), .MAX_SKEW(3), .PIPE(1),
    .TRAIN_PAT(8'hA5), .LOCK_CNT(4), .TIMEOUT(1024)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Set(Set), .Enable(Enable), .Train(Train),
    .In(In), .Out(Out), .OutValid(OutValid), .Locked(Locked),
    .TrainFail(TrainFail), .LaneDelay(LaneDelay)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (sb_en && OutValid === 1'b1) begin
      if (sb_q.size() == 0) chk("sb_unexpected_valid", 64'(sb_q.size()), 64'd1);
      else chk("sb_out", 64'(Out), 64'(sb_q.pop_front()));
    end
  end

  function automatic logic [31:0] word_at(input int j, input bit mk);
    logic [31:0] w;
    w = '0;
    if (j < 0) return w;
    if (mk && (j % 16 == 0)) return {LANES{8'hA5}};
    for (int l = 0; l < LANES; l++) w[l*8 +: 8] = 8'((j * 37 + l * 11 + seed) & 127);
    return w;
  endfunction

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Lane l carries logical word k-skew[l]; pushed words are the realigned expectations.
  task automatic stream(input int k0, input int n, input bit mk, input bit sb);
    int ms;
    logic [31:0] w;
    ms = 0;
    for (int l = 0; l < LANES; l++) if (skew[l] > ms) ms = skew[l];
    for (int k = k0; k < k0 + n; k++) begin
      for (int l = 0; l < LANES; l++) begin
        w = word_at(k - skew[l], mk);
        In[l*8 +: 8] = w[l*8 +: 8];
      end
      Enable = 1'b1;
      if (sb && k >= ms) sb_q.push_back(word_at(k - ms, mk));
      tick();
    end
    Enable = 1'b0;
  endtask

  task automatic set_skew(input int s0, input int s1, input int s2, input int s3);
    skew[0] = s0; skew[1] = s1; skew[2] = s2; skew[3] = s3;
  endtask

  task automatic pulse_train;
    Train = 1'b1;
    tick();
    Train = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Set = 1'b0; Enable = 1'b0; Train = 1'b0; In = '0;
    set_skew(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_out", 64'(Out), 64'd0);
    chk("rst_valid", 64'(OutValid), 64'd0);
    chk("rst_locked", 64'(Locked), 64'd0);
    chk("rst_fail", 64'(TrainFail), 64'd0);
    chk("rst_delay", 64'(LaneDelay), 64'd0);
    Reset = 1'b0;

    // Set forces ones; Reset overrides Set.
    Set = 1'b1;
    repeat (4) tick();
    chk("set_out", 64'(Out), 64'hFFFF_FFFF);
    chk("set_valid", 64'(OutValid), 64'd0);
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0; Set = 1'b0;
    repeat (4) tick();
    chk("rstset_out", 64'(Out), 64'd0);

    // Single capture, latency 2+PIPE with zero delays.
    In = 32'h1234_5678; Enable = 1'b1;
    tick();
    Enable = 1'b0; In = '0;
    chk("lat1_valid", 64'(OutValid), 64'd0);
    tick();
    chk("lat2_valid", 64'(OutValid), 64'd0);
    tick();
    chk("lat3_valid", 64'(OutValid), 64'd1);
    chk("lat3_out", 64'(Out), 64'h1234_5678);
    tick();
    chk("lat4_valid", 64'(OutValid), 64'd0);

    seed = 1; sb_en = 1'b1;
    stream(0, 20, 1'b0, 1'b1);
    repeat (8) tick();
    chk("sb_drain_zero", 64'(sb_q.size()), 64'd0);
    sb_en = 1'b0;

    // Zero-skew training.
    pulse_train();
    stream(0, 40, 1'b1, 1'b0);
    chk("t2_prelock", 64'(Locked), 64'd0);
    stream(40, 40, 1'b1, 1'b0);
    chk("t2_locked", 64'(Locked), 64'd1);
    chk("t2_delay", 64'(LaneDelay), 64'd0);
    chk("t2_fail", 64'(TrainFail), 64'd0);

    // Skewed training {0,2,1,3} -> delays {3,1,2,0}.
    set_skew(0, 2, 1, 3);
    pulse_train();
    stream(0, 88, 1'b1, 1'b0);
    chk("t3_delay", 64'(LaneDelay), 64'h27);
    chk("t3_locked", 64'(Locked), 64'd1);
    chk("t3_fail", 64'(TrainFail), 64'd0);
    repeat (8) tick();
    seed = 7; sb_en = 1'b1;
    stream(0, 24, 1'b0, 1'b1);
    repeat (10) tick();
    chk("sb_drain_skew", 64'(sb_q.size()), 64'd0);
    sb_en = 1'b0;
    chk("t3_hold_locked", 64'(Locked), 64'd1);

    // Reset while locked.
    Reset = 1'b1;
    tick();
    chk("t6l_locked", 64'(Locked), 64'd0);
    chk("t6l_delay", 64'(LaneDelay), 64'd0);
    chk("t6l_out", 64'(Out), 64'd0);
    chk("t6l_valid", 64'(OutValid), 64'd0);
    chk("t6l_fail", 64'(TrainFail), 64'd0);
    Reset = 1'b0;
    set_skew(0, 0, 0, 0);
    stream(0, 40, 1'b1, 1'b0);
    chk("t6l_idle_nolock", 64'(Locked), 64'd0);

    // Skew beyond MAX_SKEW.
    set_skew(0, 0, 0, 4);
    pulse_train();
    stream(0, 12, 1'b1, 1'b0);
    chk("t4_fail", 64'(TrainFail), 64'd1);
    chk("t4_locked", 64'(Locked), 64'd0);
    chk("t4_delay", 64'(LaneDelay), 64'd0);

    // Search timeout boundary, then retrain.
    set_skew(0, 0, 0, 0);
    pulse_train();
    chk("t5_cleared", 64'(TrainFail), 64'd0);
    repeat (1023) tick();
    chk("t5_before_to", 64'(TrainFail), 64'd0);
    tick();
    chk("t5_timeout", 64'(TrainFail), 64'd1);
    pulse_train();
    stream(0, 88, 1'b1, 1'b0);
    chk("t5_relock", 64'(Locked), 64'd1);
    chk("t5_refail", 64'(TrainFail), 64'd0);

    // Reset while in VERIFY with measured delays.
    set_skew(0, 2, 1, 3);
    pulse_train();
    stream(0, 8, 1'b1, 1'b0);
    chk("t6v_delay", 64'(LaneDelay), 64'h27);
    chk("t6v_notlocked", 64'(Locked), 64'd0);
    Reset = 1'b1;
    tick();
    chk("t6v_delay_rst", 64'(LaneDelay), 64'd0);
    chk("t6v_out", 64'(Out), 64'd0);
    chk("t6v_valid", 64'(OutValid), 64'd0);
    chk("t6v_fail", 64'(TrainFail), 64'd0);
    Reset = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
